decoder_stage_riscv: RTL
========================

Name: decoder_stage_riscv

Overview:
Registered decode stage for the RV32 core. It sits between fetch and execute, which replaces single-cycle combinational decode with a valid/ready pipeline stage. It decodes the fetched instruction into the execute/LSU/writeback control bundle and optionally supports the M extension. It includes a 2-entry skid buffer so that in_ready_o is driven from flops, and it supports flush and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, width of pc_i/pc_o
ENABLE_M, 1, 1 = decode RV32M (funct7=0000001 on OP); 0 = such encodings are illegal
SKID_EN, 1, 1 = 2-entry skid buffer (in_ready_o registered); 0 = single register, in_ready_o = !out_valid_o | out_ready_i
ILL_CNT_W, 8, width of illegal-instruction counter

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
in_valid_i  in  1  fetch has an instruction
in_ready_o  out  1  stage accepts
instr_i  in  32  fetched instruction
pc_i  in  XLEN  instruction address
flush_i  in  1  discard all held entries (branch/trap redirect)
out_valid_o  out  1  decoded bundle valid
out_ready_i  in  1  execute accepts (low while LSU stalls)
instr_o  out  32  held instruction (for immediate generation)
pc_o  out  XLEN  held pc
ex_op_a_sel_o  out  2  operand A select (defines_riscv OP_A_* codes)
ex_op_b_sel_o  out  3  operand B select (OP_B_* codes)
alu_op_o  out  5  ALU op
mem_req_o, mem_we_o  out  1 each  LSU request / write
mem_size_o  out  3  LDST_* code
gpr_we_a_o  out  1  register write enable
wb_src_sel_o  out  1  WB_EX_RESULT / WB_LSU_DATA
illegal_instr_o, branch_o, jal_o, jalr_o  out  1 each
ill_cnt_o  out  ILL_CNT_W  count of illegal instructions emitted

Behaviour:
- Reset (asynchronous, arst_n_i=0): all entries invalid; out_valid_o=0; in_ready_o=1; ill_cnt_o=0. All bundle outputs are 0 except ex_op_a_sel_o=OP_A_CURR_PC and ex_op_b_sel_o=OP_B_IMM_U. Reset applied mid-transfer drops the entry.
- Transfer occurs when valid&ready on a side. Decode is combinational on instr_i and is captured into the entry on input transfer. Latency is 1 cycle from input transfer to out_valid_o.
- Decode rules:
  - opcode[1:0]!=11 or unknown opcode -> illegal.
  - LOAD: rs1+immI, ADD, mem_req=1, size=funct3, gpr_we=1, WB_LSU. funct3 must be in {0,1,2,4,5}, else illegal with size=LDST_B.
  - STORE: immS, mem_req=mem_we=1. funct3 must be in {0,1,2}.
  - OP-IMM: alu_op={00,funct3}, or {01,101} for SRAI. Shift funct7 is checked (SLLI/SRLI require 0000000, SRAI requires 0100000).
  - OP: funct7=0100000 is legal only for funct3 0/5, alu={01,funct3}. funct7=0000001 with ENABLE_M gives alu={10,funct3}. Any other funct7!=0 is illegal.
  - LUI: OP_A_ZERO + immU. AUIPC: CURR_PC + immU.
  - BRANCH: alu={11,funct3}, branch=1. funct3 2/3 is illegal, with alu=ALU_EQ.
  - JAL/JALR: CURR_PC + INCR, gpr_we=1. JALR requires funct3=0.
  - MISC-MEM: no-op.
  - SYSTEM: ECALL/EBREAK flagged illegal (trap path).
  - Illegal entries force mem_req=0, mem_we=0, gpr_we=0, branch=0, jal=0, jalr=0.
- Skid mode (SKID_EN=1):
  - Main + skid registers; in_ready_o = skid empty (registered).
  - Input arrives while out_valid_o & !out_ready_i with main full -> goes to skid.
  - On output transfer, skid moves to main.
  - Full = both occupied -> in_ready_o=0 next cycle. No bubble when out_ready_i is held high.
- Ordering: strict FIFO; no entry is duplicated or lost.
- flush_i: next cycle, all entries are invalid and in_ready_o=1. An input transferring in the flush cycle is discarded. flush_i has priority over simultaneous in/out transfers.
- ill_cnt_o increments on each output transfer with illegal_instr_o=1 and saturates at all-ones. Flushed entries are not counted.
- Outputs hold stable while out_valid_o & !out_ready_i.

Test Plan:
- Reset then 0x00500093 (addi x1,x0,5) with out_ready_i=1 -> next cycle out_valid_o=1, alu_op=ADD, op_b=OP_B_IMM_I, gpr_we=1, illegal=0.
- 0x022081B3 (mul) -> ENABLE_M=1: alu_op=5'b10000, illegal=0; ENABLE_M=0: illegal=1, gpr_we=0, ill_cnt_o=1.
- Back-to-back 0x00012283 (lw) then addi with out_ready_i low 3 cycles -> in_ready_o falls after 2 accepts; outputs stay lw; on release, lw then addi in order with no loss.
- 0x00000073 (ecall) emitted 260 times with ILL_CNT_W=8 -> ill_cnt_o saturates at 255.
- flush_i with both entries full plus a simultaneous input -> next cycle out_valid_o=0, in_ready_o=1, ill_cnt_o unchanged.
- arst_n_i asserted mid-stream between clock edges -> outputs reset immediately; first post-reset instruction decoded correctly.

Source files
------------

// File: rtl/decoder_stage_riscv.sv
// RV32 registered decode stage: combinational decode of instr_i captured into a
// valid/ready pipeline entry, with an optional 2-entry skid buffer and illegal counter.
module decoder_stage_riscv #(
   parameter int XLEN      = 32,
   parameter int ENABLE_M  = 1,
   parameter int SKID_EN   = 1,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [31:0]          instr_i,
   input  logic [XLEN-1:0]      pc_i,
   input  logic                 flush_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [31:0]          instr_o,
   output logic [XLEN-1:0]      pc_o,
   output logic [1:0]           ex_op_a_sel_o,
   output logic [2:0]           ex_op_b_sel_o,
   output logic [4:0]           alu_op_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [2:0]           mem_size_o,
   output logic                 gpr_we_a_o,
   output logic                 wb_src_sel_o,
   output logic                 illegal_instr_o,
   output logic                 branch_o,
   output logic                 jal_o,
   output logic                 jalr_o,
   output logic [ILL_CNT_W-1:0] ill_cnt_o
);

   localparam logic [1:0] OP_A_REGA    = 2'd0;
   localparam logic [1:0] OP_A_CURR_PC = 2'd1;
   localparam logic [1:0] OP_A_ZERO    = 2'd2;
   localparam logic [2:0] OP_B_REGB    = 3'd0;
   localparam logic [2:0] OP_B_IMM_I   = 3'd1;
   localparam logic [2:0] OP_B_IMM_S   = 3'd2;
   localparam logic [2:0] OP_B_IMM_U   = 3'd3;
   localparam logic [2:0] OP_B_INCR    = 3'd4;
   localparam logic [4:0] ALU_ADD      = 5'b00000;
   localparam logic [4:0] ALU_EQ       = 5'b11000;
   localparam logic [2:0] LDST_B       = 3'd0;
   localparam logic       WB_EX_RESULT = 1'b0;
   localparam logic       WB_LSU_DATA  = 1'b1;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [1:0]      op_a;
      logic [2:0]      op_b;
      logic [4:0]      alu;
      logic            mem_req;
      logic            mem_we;
      logic [2:0]      size;
      logic            gpr_we;
      logic            wb;
      logic            ill;
      logic            br;
      logic            jal;
      logic            jalr;
   } bundle_t;

   function automatic bundle_t rst_bundle();
      bundle_t b;
      b      = '0;
      b.op_a = OP_A_CURR_PC;
      b.op_b = OP_B_IMM_U;
      return b;
   endfunction

   bundle_t                dec;
   bundle_t                main_q, main_d, skid_q, skid_d;
   logic                   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic [ILL_CNT_W-1:0]   ill_cnt_q, ill_cnt_d;
   logic                   in_xfer, out_xfer, ill;
   logic [6:0]             opcode, funct7;
   logic [2:0]             funct3;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   always_comb begin
      dec       = '0;
      dec.instr = instr_i;
      dec.pc    = pc_i;
      dec.op_a  = OP_A_REGA;
      dec.op_b  = OP_B_REGB;
      dec.alu   = ALU_ADD;
      dec.size  = LDST_B;
      dec.wb    = WB_EX_RESULT;
      ill       = 1'b0;
      if (opcode[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (opcode[6:2])
            5'b00000: begin // LOAD
               dec.op_b    = OP_B_IMM_I;
               dec.mem_req = 1'b1;
               dec.gpr_we  = 1'b1;
               dec.wb      = WB_LSU_DATA;
               if (funct3 == 3'd3 || funct3 > 3'd5) ill = 1'b1;
               else dec.size = funct3;
            end
            5'b01000: begin // STORE
               dec.op_b    = OP_B_IMM_S;
               dec.mem_req = 1'b1;
               dec.mem_we  = 1'b1;
               if (funct3 > 3'd2) ill = 1'b1;
               else dec.size = funct3;
            end
            5'b00100: begin // OP-IMM
               dec.op_b   = OP_B_IMM_I;
               dec.gpr_we = 1'b1;
               dec.alu    = {2'b00, funct3};
               if (funct3 == 3'd1 && funct7 != 7'b0000000) ill = 1'b1;
               if (funct3 == 3'd5) begin
                  if (funct7 == 7'b0100000) dec.alu = {2'b01, funct3};
                  else if (funct7 != 7'b0000000) ill = 1'b1;
               end
            end
            5'b01100: begin // OP
               dec.gpr_we = 1'b1;
               dec.alu    = {2'b00, funct3};
               if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
                  dec.alu = {2'b01, funct3};
               else if (funct7 == 7'b0000001 && ENABLE_M != 0)
                  dec.alu = {2'b10, funct3};
               else if (funct7 != 7'b0000000)
                  ill = 1'b1;
            end
            5'b01101: begin // LUI
               dec.op_a   = OP_A_ZERO;
               dec.op_b   = OP_B_IMM_U;
               dec.gpr_we = 1'b1;
            end
            5'b00101: begin // AUIPC
               dec.op_a   = OP_A_CURR_PC;
               dec.op_b   = OP_B_IMM_U;
               dec.gpr_we = 1'b1;
            end
            5'b11000: begin // BRANCH
               dec.alu = {2'b11, funct3};
               dec.br  = 1'b1;
               if (funct3 == 3'd2 || funct3 == 3'd3) begin
                  ill     = 1'b1;
                  dec.alu = ALU_EQ;
               end
            end
            5'b11011: begin // JAL
               dec.op_a   = OP_A_CURR_PC;
               dec.op_b   = OP_B_INCR;
               dec.gpr_we = 1'b1;
               dec.jal    = 1'b1;
            end
            5'b11001: begin // JALR
               dec.op_a   = OP_A_CURR_PC;
               dec.op_b   = OP_B_INCR;
               dec.gpr_we = 1'b1;
               dec.jalr   = 1'b1;
               if (funct3 != 3'd0) ill = 1'b1;
            end
            5'b00011: ; // MISC-MEM: fence is a no-op here
            // No CSR support in this core: every SYSTEM encoding takes the trap path.
            5'b11100: ill = 1'b1;
            default:  ill = 1'b1;
         endcase
      end
      if (ill) begin
         dec.mem_req = 1'b0;
         dec.mem_we  = 1'b0;
         dec.gpr_we  = 1'b0;
         dec.br      = 1'b0;
         dec.jal     = 1'b0;
         dec.jalr    = 1'b0;
      end
      dec.ill = ill;
   end

   assign in_ready_o = (SKID_EN != 0) ? !skid_vld_q : (!main_vld_q || out_ready_i);
   assign in_xfer    = in_valid_i && in_ready_o;
   assign out_xfer   = main_vld_q && out_ready_i;

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      ill_cnt_d  = ill_cnt_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (out_xfer && main_q.ill && ill_cnt_q != '1)
            ill_cnt_d = ill_cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
         if (!main_vld_q || out_ready_i) begin
            if (skid_vld_q) begin
               main_d     = skid_q;
               main_vld_d = 1'b1;
               skid_vld_d = 1'b0;
            end else begin
               main_vld_d = in_xfer;
               if (in_xfer) main_d = dec;
            end
         end else if (in_xfer && SKID_EN != 0) begin
            // Main is stalled with an entry: park the new one behind it.
            skid_d     = dec;
            skid_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         main_q     <= rst_bundle();
         skid_q     <= rst_bundle();
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         ill_cnt_q  <= '0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         ill_cnt_q  <= ill_cnt_d;
      end
   end

   assign out_valid_o     = main_vld_q;
   assign instr_o         = main_q.instr;
   assign pc_o            = main_q.pc;
   assign ex_op_a_sel_o   = main_q.op_a;
   assign ex_op_b_sel_o   = main_q.op_b;
   assign alu_op_o        = main_q.alu;
   assign mem_req_o       = main_q.mem_req;
   assign mem_we_o        = main_q.mem_we;
   assign mem_size_o      = main_q.size;
   assign gpr_we_a_o      = main_q.gpr_we;
   assign wb_src_sel_o    = main_q.wb;
   assign illegal_instr_o = main_q.ill;
   assign branch_o        = main_q.br;
   assign jal_o           = main_q.jal;
   assign jalr_o          = main_q.jalr;
   assign ill_cnt_o       = ill_cnt_q;

endmodule
